// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, colour type and the visibility
// state encoding used by the message/sprite overlays.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COLOR_TRANSPARENT = 12'h000;

  typedef enum logic [1:0] {
    HIDDEN    = 2'd0,
    STEADY    = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } vis_state_t;

  // Sprite is drawn only in the steady state and the lit half of a blink.
  function automatic logic vis_of(input vis_state_t s);
    return (s == STEADY) || (s == BLINK_ON);
  endfunction

endpackage

// File: rtl/sprite_vis_fsm.sv
// Frame-synchronous show/blink controller. All transitions happen only in
// frame_tick cycles, so visibility never changes in the middle of a frame.
// vis is registered alongside the state; state is exported for debug.
module sprite_vis_fsm
  import vga_pkg::*;
#(
  parameter int BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       show,
  input  logic       blink_en,
  output logic       vis,
  output logic [1:0] state
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  vis_state_t st, st_nx;
  logic [7:0] cnt, cnt_nx;

  assign state = st;

  // State, frame counter and the registered visibility flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= HIDDEN;
      cnt <= 8'd0;
      vis <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      vis <= vis_of(st_nx);
    end
  end

  // Next-state logic; only frame_tick cycles may move the state or counter.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    if (frame_tick) begin
      case (st)
        HIDDEN: begin
          cnt_nx = 8'd0;
          if (show) st_nx = blink_en ? BLINK_ON : STEADY;
        end
        STEADY: begin
          if (!show) begin
            st_nx = HIDDEN;
          end else if (blink_en) begin
            st_nx  = BLINK_ON;
            cnt_nx = 8'd0;
          end
        end
        BLINK_ON, BLINK_OFF: begin
          if (!show) begin
            st_nx = HIDDEN;
          end else if (!blink_en) begin
            st_nx = STEADY;
          end else if (cnt == LAST_FRAME) begin
            st_nx  = (st == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            cnt_nx = 8'd0;
          end else if (cnt != 8'hFF) begin
            cnt_nx = cnt + 8'd1;
          end
        end
        default: st_nx = HIDDEN;
      endcase
    end
  end

endmodule

// File: rtl/sprite_overlay.sv
// Fixed-position sprite overlay. Maps the scan position to sprite ROM
// addresses, realigns the sync-path signals with the one-cycle ROM read and
// mixes the ROM colour over the background with colour-key transparency.
// x/y/bg_rgb to rgb_out latency is exactly two clocks.
module sprite_overlay
  import vga_pkg::*;
#(
  parameter logic [9:0] SPR_X        = 10'd300,
  parameter logic [9:0] SPR_Y        = 10'd230,
  parameter int         SPR_W        = 34,
  parameter int         SPR_H        = 18,
  parameter rgb12_t     KEY_COLOR    = COLOR_TRANSPARENT,
  parameter int         BLINK_FRAMES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        show,
  input  logic        blink_en,
  input  logic [11:0] bg_rgb,
  output logic [4:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic [11:0] rgb_out,
  output logic        sprite_on
);

  // Bounds in 11 bits so SPR_X+SPR_W cannot wrap past 1023.
  localparam logic [10:0] X_LO = {1'b0, SPR_X};
  localparam logic [10:0] X_HI = {1'b0, SPR_X} + 11'(SPR_W);
  localparam logic [10:0] Y_LO = {1'b0, SPR_Y};
  localparam logic [10:0] Y_HI = {1'b0, SPR_Y} + 11'(SPR_H);

  logic [10:0] x11, y11, dx, dy;
  logic        hit;

  logic        hit_d, video_on_d;
  rgb12_t      bg_d;
  logic        vis;
  logic [1:0]  vis_state;
  logic        opaque;

  sprite_vis_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_vis (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .show       (show),
    .blink_en   (blink_en),
    .vis        (vis),
    .state      (vis_state)
  );

  // Address stage: window test and sprite-relative ROM address.
  always_comb begin
    x11     = {1'b0, x};
    y11     = {1'b0, y};
    dx      = x11 - X_LO;
    dy      = y11 - Y_LO;
    hit     = (x11 >= X_LO) && (x11 < X_HI) && (y11 >= Y_LO) && (y11 < Y_HI);
    rom_col = hit ? dx[5:0] : 6'd0;
    rom_row = hit ? dy[4:0] : 5'd0;
  end

  // Stage 1: delay hit/video_on/background to line up with rom_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d      <= 1'b0;
      video_on_d <= 1'b0;
      bg_d       <= 12'h000;
    end else begin
      hit_d      <= hit;
      video_on_d <= video_on;
      bg_d       <= bg_rgb;
    end
  end

  assign opaque = hit_d && vis && (rom_data != KEY_COLOR);

  // Stage 2: colour mix; blanking forces black outside the active region.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= 12'h000;
      sprite_on <= 1'b0;
    end else begin
      rgb_out   <= !video_on_d ? 12'h000 : (opaque ? rom_data : bg_d);
      sprite_on <= opaque && video_on_d;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed plus random bench for sprite_overlay with a behavioural ROM,
// a reference visibility model and an expected-output queue.
module tb_sprite_overlay;

  localparam int BF = 2;

  logic        clk;
  logic        reset;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_tick;
  logic        show;
  logic        blink_en;
  logic [11:0] bg_rgb;
  logic [4:0]  rom_row;
  logic [5:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb_out;
  logic        sprite_on;

  int tests = 0;
  int fails = 0;

  logic [12:0] exp_q[$];
  logic [11:0] rom_mem [0:2047];

  // reference visibility model: 0 hidden, 1 steady, 2 blink on, 3 blink off
  int mstate = 0;
  int mcnt   = 0;
  logic sh = 1'b0;
  logic bl = 1'b0;

  sprite_overlay #(
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .show       (show),
    .blink_en   (blink_en),
    .bg_rgb     (bg_rgb),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .sprite_on  (sprite_on)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered sprite ROM model
  always @(posedge clk) rom_data <= rom_mem[{rom_row, rom_col}];

  task automatic model_tick(input logic s, input logic b);
    case (mstate)
      0: begin
        mcnt = 0;
        if (s) mstate = b ? 2 : 1;
      end
      1: begin
        if (!s) mstate = 0;
        else if (b) begin mstate = 2; mcnt = 0; end
      end
      default: begin
        if (!s) mstate = 0;
        else if (!b) mstate = 1;
        else if (mcnt == BF - 1) begin
          mstate = (mstate == 2) ? 3 : 2;
          mcnt = 0;
        end else if (mcnt < 255) mcnt++;
      end
    endcase
  endtask

  task automatic check_pix(input logic [12:0] e);
    tests++;
    assert ({sprite_on, rgb_out} === e) else begin
      fails++;
      $error("FAIL pix obs on=%b rgb=%h exp on=%b rgb=%h", sprite_on, rgb_out, e[12], e[11:0]);
    end
  endtask

  // drive one pixel; compares the pixel from two cycles earlier first
  task automatic step(input int px, input int py, input logic von,
                      input logic [11:0] bg, input logic tick);
    logic        h;
    logic [4:0]  er;
    logic [5:0]  ec;
    logic [11:0] rv;
    logic        vis_m, opq;
    logic [11:0] ergb;
    @(negedge clk);
    if (exp_q.size() == 2) check_pix(exp_q.pop_front());
    x = 10'(px); y = 10'(py); video_on = von; bg_rgb = bg;
    frame_tick = tick; show = sh; blink_en = bl;
    if (tick) model_tick(sh, bl);
    h  = (px >= 300) && (px < 334) && (py >= 230) && (py < 248);
    er = h ? 5'(py - 230) : 5'd0;
    ec = h ? 6'(px - 300) : 6'd0;
    rv = rom_mem[{er, ec}];
    vis_m = (mstate == 1) || (mstate == 2);
    opq   = h && vis_m && (rv != 12'h000);
    ergb  = !von ? 12'h000 : (opq ? rv : bg);
    exp_q.push_back({opq && von, ergb});
    #1;
    tests++;
    assert ({rom_row, rom_col} === {er, ec}) else begin
      fails++;
      $error("FAIL addr x=%0d y=%0d obs row=%0d col=%0d exp row=%0d col=%0d",
             px, py, rom_row, rom_col, er, ec);
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    #1;
    for (int i = 0; i < ncyc; i++) begin
      tests++;
      assert ({sprite_on, rgb_out} === 13'h0) else begin
        fails++;
        $error("FAIL reset_out obs on=%b rgb=%h exp on=0 rgb=000", sprite_on, rgb_out);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    mstate = 0;
    mcnt = 0;
  endtask

  task automatic flush();
    repeat (2) begin
      @(negedge clk);
      if (exp_q.size() > 0) check_pix(exp_q.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 12'(i) | 12'h800;
    rom_mem[0] = 12'hCF7;
    rom_mem[{5'd5, 6'd5}] = 12'h000;
    reset = 1'b1; x = '0; y = '0; video_on = 1'b0; frame_tick = 1'b0;
    show = 1'b0; blink_en = 1'b0; bg_rgb = '0;

    // power-on reset
    do_reset(3);

    // hidden: sprite pixel shows background
    step(300, 230, 1'b1, 12'h0F0, 1'b0);

    // steady show, then pixel/boundary/transparency cases
    sh = 1'b1; bl = 1'b0;
    step(0, 0, 1'b0, 12'h000, 1'b1);
    step(300, 230, 1'b1, 12'h0F0, 1'b0);
    step(333, 247, 1'b1, 12'h0F0, 1'b0);
    step(334, 247, 1'b1, 12'h0F0, 1'b0);
    step(299, 230, 1'b1, 12'h0F0, 1'b0);
    step(300, 229, 1'b1, 12'h0F0, 1'b0);
    step(300, 248, 1'b1, 12'h0F0, 1'b0);
    step(305, 235, 1'b1, 12'h00F, 1'b0);
    step(310, 240, 1'b0, 12'h00F, 1'b0);
    step(639, 479, 1'b1, 12'hABC, 1'b0);
    step(1023, 1023, 1'b1, 12'h321, 1'b0);

    // show dropped mid-frame: still drawn until the next frame_tick
    sh = 1'b0;
    step(300, 230, 1'b1, 12'h111, 1'b0);
    step(320, 240, 1'b1, 12'h111, 1'b0);
    step(0, 0, 1'b0, 12'h000, 1'b1);
    step(300, 230, 1'b1, 12'h111, 1'b0);

    // blink: six frames, each followed by a sprite pixel
    sh = 1'b1; bl = 1'b1;
    for (int f = 0; f < 6; f++) begin
      step(0, 0, 1'b0, 12'h000, 1'b1);
      step(300, 230, 1'b1, 12'h123, 1'b0);
    end

    // blink -> steady
    bl = 1'b0;
    step(0, 0, 1'b0, 12'h000, 1'b1);
    step(301, 231, 1'b1, 12'h456, 1'b0);

    // reset mid-frame while steady, then reappear after a frame_tick
    step(300, 230, 1'b1, 12'h0F0, 1'b0);
    do_reset(3);
    step(300, 230, 1'b1, 12'h0F0, 1'b0);
    step(300, 230, 1'b1, 12'h0F0, 1'b1);
    step(300, 230, 1'b1, 12'h0F0, 1'b0);

    // random scan around the sprite window with occasional frame changes
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) sh = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bl = 1'($urandom_range(0, 1));
      step($urandom_range(290, 340), $urandom_range(225, 252),
           1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 5) == 0));
    end

    flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
